// File: rtl/line_drawer.sv
// line_drawer: rasterises one latched line into a pixel stream (Bresenham).
// Ports: clk, rst (async active-low); line_* upstream valid/ready;
//   abort; pix_* downstream valid/ready; busy; line_done pulse.
module line_drawer #(
    parameter int COORD_W = 13,
    parameter int INT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_valid,
    output logic               line_ready,
    input  logic [COORD_W-1:0] line_start_x,
    input  logic [COORD_W-1:0] line_end_x,
    input  logic [COORD_W-1:0] line_start_y,
    input  logic [COORD_W-1:0] line_end_y,
    input  logic [INT_W-1:0]   line_intensity,
    input  logic               abort,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [INT_W-1:0]   pix_intensity,
    output logic               busy,
    output logic               line_done
);

    localparam int W = COORD_W + 3;
    localparam logic signed [W-1:0] ZERO = '0;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE
    } state_t;

    state_t state;

    logic [COORD_W-1:0] sx, sy, ex, ey;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic [INT_W-1:0]   inten;
    logic               stepx_neg, stepy_neg;
    logic               pix_valid_q, line_done_q;

    logic signed [W-1:0] dx, dy, err;

    logic signed [W-1:0] sx_s, sy_s, ex_s, ey_s;
    logic signed [W-1:0] diff_x, diff_y, abs_x, abs_y;
    logic signed [W-1:0] e2, err_nxt;
    logic                x_go, y_go, at_end;

    // Zero-extended coordinates so the signed differences never overflow.
    always_comb begin
        sx_s    = $signed({3'b000, sx});
        sy_s    = $signed({3'b000, sy});
        ex_s    = $signed({3'b000, ex});
        ey_s    = $signed({3'b000, ey});
        diff_x  = ex_s - sx_s;
        diff_y  = ey_s - sy_s;
        abs_x   = diff_x[W-1] ? -diff_x : diff_x;
        abs_y   = diff_y[W-1] ? -diff_y : diff_y;
        e2      = err <<< 1;
        x_go    = (e2 >= dy);
        y_go    = (e2 <= dx);
        // Both error updates are based on the pre-update err.
        err_nxt = err + (x_go ? dy : ZERO) + (y_go ? dx : ZERO);
        at_end  = (cur_x == ex) && (cur_y == ey);
    end

    assign line_ready    = (state == IDLE);
    assign busy          = (state != IDLE);
    assign pix_valid     = pix_valid_q;
    assign line_done     = line_done_q;
    assign pix_x         = cur_x;
    assign pix_y         = cur_y;
    assign pix_intensity = inten;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sx          <= '0;
            sy          <= '0;
            ex          <= '0;
            ey          <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            inten       <= '0;
            stepx_neg   <= 1'b0;
            stepy_neg   <= 1'b0;
            dx          <= '0;
            dy          <= '0;
            err         <= '0;
            pix_valid_q <= 1'b0;
            line_done_q <= 1'b0;
        end else if (abort && state != IDLE) begin
            // Abort wins over a same-cycle pixel handshake.
            state       <= IDLE;
            pix_valid_q <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    line_done_q <= 1'b0;
                    if (line_valid) begin
                        sx    <= line_start_x;
                        sy    <= line_start_y;
                        ex    <= line_end_x;
                        ey    <= line_end_y;
                        inten <= line_intensity;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    dx          <= abs_x;
                    dy          <= -abs_y;
                    err         <= abs_x - abs_y;
                    stepx_neg   <= !(sx < ex);
                    stepy_neg   <= !(sy < ey);
                    cur_x       <= sx;
                    cur_y       <= sy;
                    pix_valid_q <= 1'b1;
                    state       <= DRAW;
                end
                DRAW: begin
                    if (pix_ready) begin
                        if (at_end) begin
                            pix_valid_q <= 1'b0;
                            line_done_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            err <= err_nxt;
                            if (x_go)
                                cur_x <= stepx_neg ? cur_x - ONE
                                                   : cur_x + ONE;
                            if (y_go)
                                cur_y <= stepy_neg ? cur_y - ONE
                                                   : cur_y + ONE;
                        end
                    end
                end
                DONE: begin
                    line_done_q <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// Directed testbench for line_drawer.
// Samples outputs and drives inputs on the falling clock edge.
module tb_line_drawer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        line_valid = 1'b0;
    logic        line_ready;
    logic [12:0] line_start_x = '0;
    logic [12:0] line_end_x = '0;
    logic [12:0] line_start_y = '0;
    logic [12:0] line_end_y = '0;
    logic [3:0]  line_intensity = '0;
    logic        abort = 1'b0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [12:0] pix_x;
    logic [12:0] pix_y;
    logic [3:0]  pix_intensity;
    logic        busy;
    logic        line_done;

    int checks = 0;
    int errors = 0;

    int qx[$];
    int qy[$];
    int qi[$];
    int qc[$];
    int done_cyc;

    line_drawer #(.COORD_W(13), .INT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .line_valid(line_valid),
        .line_ready(line_ready),
        .line_start_x(line_start_x),
        .line_end_x(line_end_x),
        .line_start_y(line_start_y),
        .line_end_y(line_end_y),
        .line_intensity(line_intensity),
        .abort(abort),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_intensity(pix_intensity),
        .busy(busy),
        .line_done(line_done)
    );

    always #5 clk = ~clk;

    task automatic set_line(input int sx, input int sy, input int ex,
                            input int ey, input int in);
        line_start_x   = sx[12:0];
        line_start_y   = sy[12:0];
        line_end_x     = ex[12:0];
        line_end_y     = ey[12:0];
        line_intensity = in[3:0];
    endtask

    // Issues one line and records every accepted pixel with its cycle.
    task automatic run_line(input int sx, input int sy, input int ex,
                            input int ey, input int in, input bit bp);
        int cyc;
        bit stall;
        int lx, ly, li;
        qx.delete(); qy.delete(); qi.delete(); qc.delete();
        done_cyc = -1;
        set_line(sx, sy, ex, ey, in);
        line_valid = 1'b1;
        pix_ready  = 1'b1;
        @(negedge clk);
        line_valid = 1'b0;
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL setup_phase: pix_valid=%0b busy=%0b, want 0 1",
                     pix_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_pixel_latency: pix_valid=%0b, want 1",
                     pix_valid);
        end
        cyc = 0;
        stall = 1'b0;
        lx = 0; ly = 0; li = 0;
        while (cyc < 20000) begin
            if (stall) begin
                checks++;
                if (pix_x !== lx[12:0] || pix_y !== ly[12:0] ||
                    pix_intensity !== li[3:0]) begin
                    errors++;
                    $display("FAIL stall_stable: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                             pix_x, pix_y, pix_intensity, lx, ly, li);
                end
            end
            pix_ready = bp ? (((cyc * 7) % 5) < 3) : 1'b1;
            stall = pix_valid && !pix_ready;
            lx = int'(pix_x);
            ly = int'(pix_y);
            li = int'(pix_intensity);
            if (pix_valid && pix_ready) begin
                qx.push_back(int'(pix_x));
                qy.push_back(int'(pix_y));
                qi.push_back(int'(pix_intensity));
                qc.push_back(cyc);
            end
            if (line_done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        pix_ready = 1'b1;
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL line_done_timeout: no line_done in %0d cycles, want done",
                     cyc);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (line_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0 ||
            line_done !== 1'b0 || pix_x !== 13'd0 || pix_y !== 13'd0 ||
            pix_intensity !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%0b pv=%0b busy=%0b done=%0b x=%0d y=%0d i=%0d, want 1 0 0 0 0 0 0",
                     line_ready, pix_valid, busy, line_done,
                     pix_x, pix_y, pix_intensity);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_horizontal();
        run_line(0, 0, 3, 0, 5, 1'b0);
        checks++;
        if (qx.size() != 4) begin
            errors++;
            $display("FAIL horiz_count: got %0d want 4", qx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (qx[i] != i || qy[i] != 0 || qi[i] != 5 || qc[i] != i) begin
                    errors++;
                    $display("FAIL horiz_pix%0d: got (%0d,%0d,%0d)@%0d want (%0d,0,5)@%0d",
                             i, qx[i], qy[i], qi[i], qc[i], i, i);
                end
            end
        end
        checks++;
        if (done_cyc != 4 || pix_valid !== 1'b0 || line_ready !== 1'b0) begin
            errors++;
            $display("FAIL horiz_done: done@%0d pv=%0b rdy=%0b want done@4 pv=0 rdy=0",
                     done_cyc, pix_valid, line_ready);
        end
        @(negedge clk);
        checks++;
        if (line_ready !== 1'b1 || line_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL horiz_idle: rdy=%0b done=%0b busy=%0b want 1 0 0",
                     line_ready, line_done, busy);
        end
    endtask

    task automatic test_steep();
        int ax[4] = '{0, 0, 1, 1};
        int ay[4] = '{0, 1, 2, 3};
        int bx[4] = '{10, 9, 8, 7};
        int by[4] = '{10, 11, 12, 13};
        run_line(0, 0, 1, 3, 2, 1'b0);
        checks++;
        if (qx.size() != 4) begin
            errors++;
            $display("FAIL steep_count: got %0d want 4", qx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (qx[i] != ax[i] || qy[i] != ay[i]) begin
                    errors++;
                    $display("FAIL steep_pix%0d: got (%0d,%0d) want (%0d,%0d)",
                             i, qx[i], qy[i], ax[i], ay[i]);
                end
            end
        end
        @(negedge clk);
        run_line(10, 10, 7, 13, 1, 1'b0);
        checks++;
        if (qx.size() != 4) begin
            errors++;
            $display("FAIL rev_count: got %0d want 4", qx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (qx[i] != bx[i] || qy[i] != by[i]) begin
                    errors++;
                    $display("FAIL rev_pix%0d: got (%0d,%0d) want (%0d,%0d)",
                             i, qx[i], qy[i], bx[i], by[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_extremes();
        int bad;
        run_line(8191, 0, 0, 8191, 15, 1'b0);
        checks++;
        if (qx.size() != 8192) begin
            errors++;
            $display("FAIL diag_count: got %0d want 8192", qx.size());
        end else begin
            checks++;
            if (qx[0] != 8191 || qy[0] != 0 ||
                qx[8191] != 0 || qy[8191] != 8191) begin
                errors++;
                $display("FAIL diag_ends: first (%0d,%0d) last (%0d,%0d) want (8191,0) (0,8191)",
                         qx[0], qy[0], qx[8191], qy[8191]);
            end
            bad = -1;
            for (int i = 0; i < 8192; i++)
                if (bad < 0 && (qx[i] != 8191 - i || qy[i] != i))
                    bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL diag_path: pixel %0d got (%0d,%0d) want (%0d,%0d)",
                         bad, qx[bad], qy[bad], 8191 - bad, bad);
            end
        end
        @(negedge clk);
        run_line(42, 42, 42, 42, 6, 1'b0);
        checks++;
        if (qx.size() != 1 || done_cyc != 1) begin
            errors++;
            $display("FAIL point_count: got %0d pixels done@%0d want 1 done@1",
                     qx.size(), done_cyc);
        end else begin
            checks++;
            if (qx[0] != 42 || qy[0] != 42 || qi[0] != 6) begin
                errors++;
                $display("FAIL point_pix: got (%0d,%0d,%0d) want (42,42,6)",
                         qx[0], qy[0], qi[0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int ex_x[6] = '{0, 1, 2, 3, 4, 5};
        int ex_y[6] = '{0, 0, 1, 1, 2, 2};
        int rx[$];
        int ry[$];
        run_line(0, 0, 5, 2, 3, 1'b0);
        rx = qx;
        ry = qy;
        @(negedge clk);
        run_line(0, 0, 5, 2, 3, 1'b1);
        checks++;
        if (qx.size() != 6 || rx.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d/%0d want 6/6",
                     qx.size(), rx.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (qx[i] != ex_x[i] || qy[i] != ex_y[i] ||
                    rx[i] != ex_x[i] || ry[i] != ex_y[i] || qi[i] != 3) begin
                    errors++;
                    $display("FAIL bp_pix%0d: stall (%0d,%0d) free (%0d,%0d) want (%0d,%0d)",
                             i, qx[i], qy[i], rx[i], ry[i], ex_x[i], ex_y[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        set_line(0, 0, 9, 0, 3);
        line_valid = 1'b1;
        pix_ready  = 1'b1;
        @(negedge clk);
        line_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1 || pix_x !== 13'd2) begin
            errors++;
            $display("FAIL abort_third: pv=%0b x=%0d want 1 2", pix_valid, pix_x);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || line_done !== 1'b0 ||
            line_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: busy=%0b pv=%0b done=%0b rdy=%0b want 0 0 0 1",
                     busy, pix_valid, line_done, line_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (line_done !== 1'b0 || pix_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: done=%0b pv=%0b want 0 0",
                         i, line_done, pix_valid);
            end
        end
    endtask

    task automatic test_reset_midline();
        set_line(0, 0, 9, 0, 4);
        line_valid = 1'b1;
        @(negedge clk);
        line_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || line_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: pv=%0b busy=%0b rdy=%0b want 0 0 1",
                     pix_valid, busy, line_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_line(1, 1, 2, 1, 9, 1'b0);
        checks++;
        if (qx.size() != 2 || done_cyc != 2) begin
            errors++;
            $display("FAIL post_reset_count: got %0d done@%0d want 2 done@2",
                     qx.size(), done_cyc);
        end else begin
            checks++;
            if (qx[0] != 1 || qy[0] != 1 || qx[1] != 2 || qy[1] != 1 ||
                qi[0] != 9 || qi[1] != 9) begin
                errors++;
                $display("FAIL post_reset_pix: got (%0d,%0d) (%0d,%0d) want (1,1) (2,1)",
                         qx[0], qy[0], qx[1], qy[1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_isolation();
        int n;
        int seen_done;
        n = 0;
        seen_done = 0;
        qx.delete(); qy.delete(); qi.delete();
        set_line(0, 0, 3, 0, 7);
        line_valid = 1'b1;
        pix_ready  = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 50; c++) begin
            set_line(100 + c, 200 + c, 300 - c, 50 + c, c % 16);
            checks++;
            if (line_ready !== 1'b0) begin
                errors++;
                $display("FAIL iso_ready%0d: rdy=%0b want 0", c, line_ready);
            end
            if (pix_valid && pix_ready) begin
                qx.push_back(int'(pix_x));
                qy.push_back(int'(pix_y));
                qi.push_back(int'(pix_intensity));
            end
            if (line_done) begin
                seen_done = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (seen_done == 0) begin
            errors++;
            $display("FAIL iso_timeout: no line_done, want done");
        end
        @(negedge clk);
        checks++;
        if (line_ready !== 1'b1) begin
            errors++;
            $display("FAIL iso_ready_after: rdy=%0b want 1", line_ready);
        end
        line_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL iso_no_accept: busy=%0b want 0", busy);
        end
        checks++;
        if (qx.size() != 4) begin
            errors++;
            $display("FAIL iso_count: got %0d want 4", qx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (qx[i] != i || qy[i] != 0 || qi[i] != 7) begin
                    errors++;
                    $display("FAIL iso_pix%0d: got (%0d,%0d,%0d) want (%0d,0,7)",
                             i, qx[i], qy[i], qi[i], i);
                end
                n++;
            end
            checks += n;
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_extremes();
        test_backpressure();
        test_abort();
        test_reset_midline();
        test_isolation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_drawer.md
Name: line_drawer

Overview:
- Consumer of the line register: takes one latched line (start/end X/Y, intensity) and rasterises it into a pixel stream using integer Bresenham.
- Sits between the line register and the framebuffer/pixel writer.
- Upstream handshake is valid/ready; downstream pixel handshake is valid/ready with backpressure.
- Emits exactly max(|dx|,|dy|)+1 pixels per line, then pulses done.

Parameters:
- COORD_W, 13, coordinate width (unsigned screen coordinates).
- INT_W, 4, intensity width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- line_valid  in  1  a line is available on the line_* inputs.
- line_ready  out  1  block accepts a line this cycle.
- line_start_x  in  COORD_W  start X.
- line_end_x  in  COORD_W  end X.
- line_start_y  in  COORD_W  start Y.
- line_end_y  in  COORD_W  end Y.
- line_intensity  in  INT_W  intensity applied to every pixel of the line.
- abort  in  1  synchronous cancel of the current line.
- pix_valid  out  1  pix_x/pix_y/pix_intensity hold a pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x  out  COORD_W  pixel X.
- pix_y  out  COORD_W  pixel Y.
- pix_intensity  out  INT_W  pixel intensity.
- busy  out  1  high whenever state != IDLE.
- line_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; line_ready=1 (combinational from IDLE); pix_valid=0; pix_x/pix_y/pix_intensity=0; busy=0; line_done=0; all internal registers cleared.
- Reset mid-line: drops the line immediately; no further pixels; no line_done.
- States: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - line_ready=1.
  - On line_valid&line_ready, register all line_* inputs and go to SETUP.
- SETUP (1 cycle):
  - dx = |ex-sx|; dy = -|ey-sy|.
  - stepx = +1 if sx<ex else -1; stepy = +1 if sy<ey else -1.
  - err = dx+dy.
  - Load cur_x=sx, cur_y=sy. Go to DRAW.
- DRAW:
  - pix_valid=1; pix_x=cur_x, pix_y=cur_y, pix_intensity=latched intensity.
  - Outputs stay stable while pix_valid&!pix_ready.
  - On pix_valid&pix_ready:
    - If cur_x==ex and cur_y==ey, go to DONE.
    - Else compute e2=2*err.
    - If e2>=dy: err+=dy, cur_x+=stepx.
    - If e2<=dx: err+=dx, cur_y+=stepy.
    - Both updates use the pre-update err, applied in the same cycle.
- DONE (1 cycle): pix_valid=0, line_done=1, then go to IDLE.
- Latency: first pixel has pix_valid high 2 cycles after the accept edge. With pix_ready held high, one pixel per cycle follows. Next line can be accepted the cycle after DONE.
- Widths:
  - dx, dy, err and e2 are signed COORD_W+3 bits (16 for default). Covers ±4*8191 with no overflow.
  - cur_x/cur_y are COORD_W unsigned. They never step outside [min(s,e), max(s,e)], so there is no wrap.
- Degenerate line (start==end): exactly one pixel, then DONE.
- abort (any non-IDLE state): next edge goes to IDLE, pix_valid=0, no line_done. abort in IDLE is ignored. abort overrides a simultaneous pixel handshake; that pixel counts as delivered.
- line_valid outside IDLE: ignored, line_ready=0. Inputs may change freely; latched copies are used.

Test Plan:
- Horizontal: (0,0)->(3,0), int=5, pix_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0), each int=5, on consecutive cycles; line_done 1 cycle after the last pixel; line_ready back high the following cycle.
- Steep: (0,0)->(1,3) -> exactly (0,0),(0,1),(1,2),(1,3). Reverse direction (10,10)->(7,13) -> (10,10),(9,11),(8,12),(7,13).
- Extremes/degenerate: (8191,0)->(0,8191) -> 8192 pixels, first (8191,0), last (0,8191), no overflow. (42,42)->(42,42) -> single pixel (42,42), then line_done.
- Backpressure: toggle pix_ready randomly on (0,0)->(5,2) -> pix_x/pix_y stable while stalled; sequence identical to the pix_ready=1 run; pixel count 6.
- Abort and reset: assert abort during the 3rd pixel of (0,0)->(9,0) -> IDLE next cycle, no line_done. Assert rst=0 asynchronously mid-line -> pix_valid and busy drop without a clock edge; after release, a new line (1,1)->(2,1) draws correctly.
- Handshake isolation: hold line_valid=1 with changing data during DRAW -> data ignored; line_ready=0 until DONE has completed.
